bist_cmd_fifo: RTL
==================

# bist_cmd_fifo

Parametrised successor to the BIST command/data capture register. It queues up to DEPTH command words and splits each into a command field and a data field, with a valid/pop handshake toward the BIST controller and full/overflow status toward the JTAG data-register side. This lets the TAP side shift several BIST commands back-to-back while the controller consumes them at its own pace.

## Interface
Parameters:
- COM_W, 8, command field width (upper bits of In)
- DATA_W, 8, data field width (lower bits of In)
- DEPTH, 4, number of entries; power of two, at least 2
- CNT_W, $clog2(DEPTH)+1, width of the occupancy count (derived, not overridden)

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- Bufer_res  input  1  reset; synchronous and active-high
- Bufer_write_en  input  1  push request; In is sampled on the same edge
- In  input  COM_W+DATA_W  word to queue; In[COM_W+DATA_W-1:DATA_W] is the command, In[DATA_W-1:0] is the data
- Bufer_pop  input  1  consumer pops the head entry
- Out_com  output  COM_W  command field of the head entry; 0 when empty
- Out_data  output  DATA_W  data field of the head entry; 0 when empty
- Out_valid  output  1  head entry present (equals !empty)
- full  output  1  count == DEPTH
- empty  output  1  count == 0
- count  output  CNT_W  current occupancy, 0..DEPTH
- overflow  output  1  sticky flag; a push was dropped

## Operation
- Storage: DEPTH×(COM_W+DATA_W) array, rd_ptr and wr_ptr of $clog2(DEPTH) bits, plus count. Both pointers wrap naturally from DEPTH-1 to 0.
- Push is accepted when Bufer_write_en && (!full || Bufer_pop). An accepted push writes In to mem[wr_ptr] and advances wr_ptr.
- Pop is accepted when Bufer_pop && !empty. An accepted pop advances rd_ptr. Bufer_pop while empty is ignored; there is no error flag for it.
- Count update: +1 on push only, −1 on pop only, unchanged when both or neither are accepted.
- Simultaneous push and pop:
  - When full, both are accepted; count stays at DEPTH.
  - When empty, only the push is accepted; count becomes 1.
- Overflow: Bufer_write_en && full && !Bufer_pop drops the word. Storage and pointers are unchanged, and overflow is set to 1. It stays 1 until Bufer_res.
- Outputs are first-word-fall-through. Out_com and Out_data are taken combinationally from mem[rd_ptr] (registered storage) and gated to 0 when empty.
- Reset (Bufer_res = 1), which has priority over push and pop in the same cycle:
  - rd_ptr = wr_ptr = count = 0 and overflow = 0.
  - Resulting outputs: Out_com = 0, Out_data = 0, Out_valid = 0, full = 0, empty = 1.
  - Memory contents are not cleared; they are masked by empty.
- Reset mid-operation discards all queued entries. No partial pop completes.
- The power-up (initial) values of all registers equal their reset values.

## Timing
- Push-to-head latency is 1 cycle. A word written at edge N into an empty FIFO gives Out_valid = 1 with that word on Out_com/Out_data from just after edge N.
- A pop at edge N presents the next entry, or zeros if now empty, immediately after edge N.
- full, empty, count and overflow are registered or decoded from registers. They change only on clock edges, with no combinational path from inputs.
- There is no combinational path from In, Bufer_write_en or Bufer_pop to any output.
- Throughput is one push and one pop per cycle, sustained.

## Structure
- Shared package bist_pkg holds:
  - the default widths COM_W_DEF = 8 and DATA_W_DEF = 8;
  - a localparam function for the field split, so the command/data bit positions are defined in one place.
- One sub-module is natural: bist_fifo_mem, a simple dual-index register array with synchronous write and asynchronous read. It has no reset.
- Pointer, count and flag logic stay in bist_cmd_fifo.

## Test plan
All scenarios use DEPTH = 4, COM_W = 8 and DATA_W = 8.
- Reset, then idle: count = 0, empty = 1, Out_valid = 0, Out_com = Out_data = 0, overflow = 0.
- Push 16'hA155, no pop: next cycle Out_com = 8'hA1, Out_data = 8'h55, count = 1. Then pop: empty = 1, outputs = 0.
- Push 16'h0101, 16'h0202, 16'h0303 and 16'h0404 on consecutive cycles: full = 1, count = 4. A fifth push of 16'h0505 sets overflow = 1, and popping four times yields 01, 02, 03, 04 in order.
- While full, push 16'h0606 together with a pop: count stays 4, overflow is unchanged, and after further pops 06 appears last. Continue until the pointers wrap twice; order is preserved.
- While empty, push 16'hBEEF together with a pop: count = 1 and head = BE/EF. Bufer_pop alone while empty leaves count = 0.
- With 3 entries and overflow = 1, assert Bufer_res together with a push and a pop: next cycle count = 0, empty = 1, overflow = 0, outputs = 0.

Source files
------------

// File: rtl/bist_pkg.sv
// bist_pkg: shared definitions for the BIST command FIFO.
//   COM_W_DEF / DATA_W_DEF : default command and data field widths
//   com_lsb / com_msb      : bit positions of the command field inside a
//                            queued word; the data field occupies [DATA_W-1:0]
package bist_pkg;

   localparam int unsigned COM_W_DEF  = 8;
   localparam int unsigned DATA_W_DEF = 8;

   // Command field sits directly above the data field.
   function automatic int unsigned com_lsb(input int unsigned data_w);
      return data_w;
   endfunction

   function automatic int unsigned com_msb(input int unsigned com_w,
                                           input int unsigned data_w);
      return com_w + data_w - 1;
   endfunction

endpackage

// File: rtl/bist_fifo_mem.sv
// bist_fifo_mem: register array with synchronous write, asynchronous read.
// No reset; contents are qualified by the owner's occupancy logic.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : write word
//   raddr : read index
//   rdata : word at raddr (combinational)
module bist_fifo_mem #(
   parameter int unsigned W     = 16,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [AW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/bist_cmd_fifo.sv
// bist_cmd_fifo: DEPTH-entry first-word-fall-through queue of BIST command
// words, split into command and data fields at the head.
//   clk            : clock
//   Bufer_res      : synchronous active-high reset
//   Bufer_write_en : push In
//   In             : {command, data}
//   Bufer_pop      : pop head entry
//   Out_com        : head command field, 0 when empty
//   Out_data       : head data field, 0 when empty
//   Out_valid      : head present
//   full / empty   : occupancy decodes
//   count          : occupancy 0..DEPTH
//   overflow       : sticky, a push was dropped while full
module bist_cmd_fifo
   import bist_pkg::*;
#(
   parameter int unsigned COM_W  = COM_W_DEF,
   parameter int unsigned DATA_W = DATA_W_DEF,
   parameter int unsigned DEPTH  = 4,
   parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                    clk,
   input  logic                    Bufer_res,
   input  logic                    Bufer_write_en,
   input  logic [COM_W+DATA_W-1:0] In,
   input  logic                    Bufer_pop,
   output logic [COM_W-1:0]        Out_com,
   output logic [DATA_W-1:0]       Out_data,
   output logic                    Out_valid,
   output logic                    full,
   output logic                    empty,
   output logic [CNT_W-1:0]        count,
   output logic                    overflow
);

   localparam int unsigned W     = COM_W + DATA_W;
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned C_LSB = com_lsb(DATA_W);
   localparam int unsigned C_MSB = com_msb(COM_W, DATA_W);

   // Declaration initialisers give power-up state equal to reset state.
   logic [PTR_W-1:0] rd_ptr   = '0;
   logic [PTR_W-1:0] wr_ptr   = '0;
   logic [CNT_W-1:0] cnt_q    = '0;
   logic             ovf_q    = 1'b0;

   logic             push_ok;
   logic             pop_ok;
   logic [W-1:0]     head;

   assign full  = (cnt_q == CNT_W'(DEPTH));
   assign empty = (cnt_q == '0);

   // A pop frees the slot a simultaneous push needs when full.
   assign push_ok = Bufer_write_en && (!full || Bufer_pop);
   assign pop_ok  = Bufer_pop && !empty;

   always_ff @(posedge clk) begin
      if (Bufer_res) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop_ok)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
         if (Bufer_write_en && full && !Bufer_pop)
            ovf_q <= 1'b1;
      end
   end

   // Write is suppressed during reset so a reset cycle leaves storage untouched.
   bist_fifo_mem #(
      .W     (W),
      .DEPTH (DEPTH),
      .AW    (PTR_W)
   ) u_mem (
      .clk   (clk),
      .we    (push_ok && !Bufer_res),
      .waddr (wr_ptr),
      .wdata (In),
      .raddr (rd_ptr),
      .rdata (head)
   );

   assign Out_valid = !empty;
   assign Out_com   = empty ? '0 : head[C_MSB:C_LSB];
   assign Out_data  = empty ? '0 : head[DATA_W-1:0];
   assign count     = cnt_q;
   assign overflow  = ovf_q;

endmodule
